// File: rtl/ibus_decoder.sv
// ibus_decoder: FlySky iBUS frame decoder.
// Receives bytes from a UART and checks the header and checksum of each frame.
// Only a verified frame is copied into 14 committed 16-bit channel registers.
// Optional feature macro: IBUS_FAILSAFE_EN adds a link-loss timer that drives
// the failsafe output. Without it, failsafe is tied to 0.
//
// Byte handshake: rxDataReady is a one-cycle valid strobe for rxData. There is
// no backpressure. The block takes one byte per cycle in every state except
// CHECK. A byte that arrives during CHECK is dropped.
module ibus_decoder #(
  parameter int CHANNELS     = 14,
  parameter int GAP_CLKS     = 8000,
  parameter int TIMEOUT_CLKS = 1600000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        rxDataReady,
  input  logic [7:0]  rxData,
  input  logic [3:0]  chSel,
  output logic [15:0] chValue,
  output logic        frameValid,
  output logic        frameErr,
  output logic [7:0]  errCount,
  output logic        failsafe,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CKLO    = 3'd3,
    S_CKHI    = 3'd4,
    S_CHECK   = 3'd5
  } state_e;

  localparam int          GW       = $clog2(GAP_CLKS + 1);
  localparam logic [3:0]  CH_LIMIT = 4'(CHANNELS);
  // 0xFFFF minus the two header bytes (0x20 + 0x40)
  localparam logic [15:0] SUM_INIT = 16'hFF9F;

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   sum_q, sum_d;
  logic [15:0]   ck_q, ck_d;
  logic          chk_ok_q, chk_ok_d;
  logic          chk_bad_q, chk_bad_d;
  logic          wr_en;
  logic [GW-1:0] gap_q;
  logic          gap_expired;
  logic [15:0]   shadow_q [CHANNELS];
  logic [15:0]   chan_q   [CHANNELS];
  logic [15:0]   chValue_q;
  logic          frameValid_q, frameErr_q;
  logic [7:0]    errCount_q;

  assign gap_expired = (gap_q == GW'(GAP_CLKS));

  // Idle counter: clears on each byte, otherwise counts up and saturates
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)               gap_q <= '0;
    else if (rxDataReady)      gap_q <= '0;
    else if (!gap_expired)     gap_q <= gap_q + GW'(1);
  end

  // Next-state logic for the frame parser. An incoming byte takes priority over gap expiry.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    ck_d      = ck_q;
    chk_ok_d  = 1'b0;
    chk_bad_d = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_HDR0: if (rxDataReady && rxData == 8'h20) state_d = S_HDR1;
      S_HDR1: if (rxDataReady) begin
        if (rxData == 8'h40) begin
          state_d = S_PAYLOAD;
          sum_d   = SUM_INIT;
          idx_d   = 5'd0;
        end else if (rxData != 8'h20) begin
          state_d = S_HDR0;
        end
      end
      S_PAYLOAD: if (rxDataReady) begin
        wr_en = 1'b1;
        sum_d = sum_q - {8'h00, rxData};
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd27) state_d = S_CKLO;
      end
      S_CKLO: if (rxDataReady) begin
        ck_d[7:0] = rxData;
        state_d   = S_CKHI;
      end
      S_CKHI: if (rxDataReady) begin
        ck_d[15:8] = rxData;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        chk_ok_d  = (ck_q == sum_q);
        chk_bad_d = (ck_q != sum_q);
        state_d   = S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase
    if (!rxDataReady && gap_expired && state_q != S_HDR0 && state_q != S_CHECK)
      state_d = S_HDR0;
  end

  // Parser state, byte index, running sum, latched checksum and check result
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_HDR0;
      idx_q     <= '0;
      sum_q     <= '0;
      ck_q      <= '0;
      chk_ok_q  <= 1'b0;
      chk_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      ck_q      <= ck_d;
      chk_ok_q  <= chk_ok_d;
      chk_bad_q <= chk_bad_d;
    end
  end

  // Shadow buffer: even byte index fills the low byte, odd index fills the high byte
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
    end else if (wr_en) begin
      if (idx_q[0]) shadow_q[idx_q[4:1]][15:8] <= rxData;
      else          shadow_q[idx_q[4:1]][7:0]  <= rxData;
    end
  end

  // Committed channels change only when a frame's checksum has verified
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < CHANNELS; i++) chan_q[i] <= '0;
    end else if (chk_ok_q) begin
      for (int i = 0; i < CHANNELS; i++) chan_q[i] <= shadow_q[i];
    end
  end

  // Status pulses and saturating checksum-error counter
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frameValid_q <= 1'b0;
      frameErr_q   <= 1'b0;
      errCount_q   <= '0;
    end else begin
      frameValid_q <= chk_ok_q;
      frameErr_q   <= chk_bad_q;
      if (chk_bad_q && errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
    end
  end

  // Registered read port: an out-of-range index reads 0
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)              chValue_q <= '0;
    else if (chSel < CH_LIMIT) chValue_q <= chan_q[chSel];
    else                      chValue_q <= '0;
  end

  assign chValue    = chValue_q;
  assign frameValid = frameValid_q;
  assign frameErr   = frameErr_q;
  assign errCount   = errCount_q;
  assign dbgState   = state_q;

`ifdef IBUS_FAILSAFE_EN
  localparam int LW = $clog2(TIMEOUT_CLKS + 1);
  logic [LW-1:0] link_q;
  logic          failsafe_q;

  // Link-loss timer. A commit clears the timer and overrides a timeout on the same edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      link_q     <= '0;
      failsafe_q <= 1'b1;
    end else if (chk_ok_q) begin
      link_q     <= '0;
      failsafe_q <= 1'b0;
    end else if (link_q == LW'(TIMEOUT_CLKS)) begin
      failsafe_q <= 1'b1;
    end else begin
      link_q <= link_q + LW'(1);
    end
  end

  assign failsafe = failsafe_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CLKS == 0);
  assign failsafe       = 1'b0;
`endif

endmodule

// File: tb/tb_ibus_decoder.sv
// tb_ibus_decoder: directed frames. Each frame's expected outcome goes into a
// scoreboard queue. A monitor pops one entry per status pulse and compares it.
module tb_ibus_decoder;

  localparam int GAP = 8000;
  localparam int TMO = 3000;
  localparam int W   = 42;  // {cycle[31:0], kind[1:0], errCount[7:0]}

`ifdef IBUS_FAILSAFE_EN
  localparam int FS_RESET = 1;
`else
  localparam int FS_RESET = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        rxDataReady = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic [3:0]  chSel = 4'd0;
  logic [15:0] chValue;
  logic        frameValid, frameErr, failsafe;
  logic [7:0]  errCount;
  logic [2:0]  dbgState;

  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  ibus_decoder #(.CHANNELS(14), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) dut (
    .clock(clock), .resetN(resetN), .rxDataReady(rxDataReady), .rxData(rxData),
    .chSel(chSel), .chValue(chValue), .frameValid(frameValid), .frameErr(frameErr),
    .errCount(errCount), .failsafe(failsafe), .dbgState(dbgState)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  int         exp_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_got;
  logic [7:0] fb [32];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: one queue entry per frameValid/frameErr pulse (kind, errCount, cycle)
  always @(negedge clock) begin
    if (frameValid || frameErr) begin
      checks++;
      if (frameValid && frameErr) begin
        errors++;
        $display("FAIL status_pulse both frameValid and frameErr high at cycle %0d", cycle_cnt);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL status_pulse unexpected frameValid=%0b frameErr=%0b at cycle %0d",
                 frameValid, frameErr, cycle_cnt);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {cycle_cnt[31:0], (frameErr ? 2'd2 : 2'd1), errCount};
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL status_pulse got cycle=%0d kind=%0d errCount=%0d expected cycle=%0d kind=%0d errCount=%0d",
                   mon_got[41:10], mon_got[9:8], mon_got[7:0],
                   mon_exp[41:10], mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rxDataReady = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rxDataReady = 1'b1;
    rxData      = b;
  endtask

  task automatic build_frame(input int base, input bit corrupt);
    logic [15:0] v, sum, cks;
    fb[0] = 8'h20;
    fb[1] = 8'h40;
    for (int i = 0; i < 14; i++) begin
      v = 16'(base + i);
      fb[2 + 2*i] = v[7:0];
      fb[3 + 2*i] = v[15:8];
    end
    sum = 16'h0000;
    for (int i = 0; i < 30; i++) sum = sum + {8'h00, fb[i]};
    cks   = 16'hFFFF - sum;
    fb[30] = cks[7:0] ^ {7'b0, corrupt};
    fb[31] = cks[15:8];
  endtask

  // Full frame; the outcome is pushed when byte 31 goes out (pulse due 3 edges later)
  task automatic send_frame(input int base, input bit corrupt);
    build_frame(base, corrupt);
    for (int i = 0; i < 31; i++) send_byte(fb[i]);
    send_byte(fb[31]);
    if (corrupt && exp_err < 255) exp_err++;
    exp_q.push_back({32'(cycle_cnt + 3), (corrupt ? 2'd2 : 2'd1), 8'(exp_err)});
    idle(4);
  endtask

  task automatic read_ch(input string name, input logic [3:0] sel, input int exp);
    @(negedge clock);
    rxDataReady = 1'b0;
    chSel = sel;
    @(negedge clock);
    check(name, chValue, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetN = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    check("reset_chValue", chValue, 0);
    check("reset_errCount", errCount, 0);
    check("reset_frameValid", frameValid, 0);
    check("reset_frameErr", frameErr, 0);
    check("reset_failsafe", failsafe, FS_RESET);

    // Valid frame, ch[i] = 1000 + i
    send_frame(1000, 1'b0);
    read_ch("valid_ch5", 4'd5, 1005);
    read_ch("valid_ch13", 4'd13, 1013);
    read_ch("valid_ch0", 4'd0, 1000);
    check("valid_errCount", errCount, 0);
    check("valid_failsafe", failsafe, 0);

    // Reset asserted while byte 15 is on the wire
    build_frame(1500, 1'b0);
    for (int i = 0; i < 15; i++) send_byte(fb[i]);
    @(negedge clock);
    rxDataReady = 1'b1;
    rxData      = fb[15];
    resetN      = 1'b0;
    idle(3);
    resetN  = 1'b1;
    exp_err = 0;
    read_ch("midreset_ch5", 4'd5, 0);
    check("midreset_errCount", errCount, 0);
    check("midreset_failsafe", failsafe, FS_RESET);

    // Checksum byte 30 flipped: error pulse, channels unchanged
    send_frame(1000, 1'b1);
    check("badck_errCount", errCount, 1);
    read_ch("badck_ch5", 4'd5, 0);

    // Resync: 0x20 0x20 0x40 ...
    send_byte(8'h20);
    send_frame(2000, 1'b0);
    read_ch("resync_ch5", 4'd5, 2005);
    read_ch("resync_ch12", 4'd12, 2012);

    // Gap abort after byte 10, then a fresh frame
    build_frame(3000, 1'b0);
    for (int i = 0; i < 11; i++) send_byte(fb[i]);
    idle(GAP + 1);
    send_frame(4000, 1'b0);
    read_ch("gap_ch5", 4'd5, 4005);
    read_ch("gap_ch0", 4'd0, 4000);
    check("gap_errCount", errCount, 1);

    // Out-of-range read index
    read_ch("sel14_zero", 4'd14, 0);
    read_ch("sel15_zero", 4'd15, 0);

`ifdef IBUS_FAILSAFE_EN
    idle(TMO + 50);
    check("timeout_failsafe", failsafe, 1);
    read_ch("timeout_hold_ch5", 4'd5, 4005);
    send_frame(5000, 1'b0);
    check("recover_failsafe", failsafe, 0);
    read_ch("recover_ch5", 4'd5, 5005);
`endif

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_frame(6000 + k, 1'b1);
    check("sat_errCount", errCount, 255);

    idle(10);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_decoder.md
# ibus_decoder

Consumes the byte stream from the receiver UART (`rxDataReady` / `rxData`, 8N1 at 115200) and decodes FlySky iBUS servo frames into 14 committed 16-bit channel registers. A frame is committed only after its header and checksum are verified, so downstream mixer/PID logic never sees a partially updated channel set. An optional link-loss timer raises a failsafe flag when valid frames stop arriving.

## Interface
Parameters:
- `CHANNELS`, 14: channel slots per frame. Frame length is fixed at 32 bytes, so only 14 is legal.
- `GAP_CLKS`, 8000: idle clocks between bytes that abort a partial frame (500 µs at 16 MHz).
- `TIMEOUT_CLKS`, 1600000: clocks without a committed frame before failsafe asserts (100 ms at 16 MHz). Used only with `IBUS_FAILSAFE_EN`.

Ports:
- `clock` in 1: system clock. One clock domain for the whole block.
- `resetN` in 1: reset, asynchronous and active-low.
- `rxDataReady` in 1: one-cycle strobe that marks `rxData` valid.
- `rxData` in 8: received byte.
- `chSel` in 4: channel read index, 0..13.
- `chValue` out 16: committed value of channel `chSel`, registered.
- `frameValid` out 1: one-cycle pulse when a frame is committed.
- `frameErr` out 1: one-cycle pulse when a checksum does not match.
- `errCount` out 8: count of checksum failures. Saturates at 255.
- `failsafe` out 1: link-loss flag.

## Operation
Frame format, byte index 0..31:
- Byte 0 = 0x20, byte 1 = 0x40.
- Bytes 2..29 = 14 channels, little-endian.
- Bytes 30..31 = checksum, little-endian. It must equal 0xFFFF minus the sum of bytes 0..29, computed modulo 2^16.

State machine:
- The FSM acts only on cycles where `rxDataReady`=1.
- HDR0: byte 0x20 → HDR1. Any other byte stays in HDR0.
- HDR1: byte 0x40 → PAYLOAD, with the sum initialised to 0xFF9F and the byte index set to 0. Byte 0x20 stays in HDR1 (resync). Any other byte → HDR0.
- PAYLOAD: each byte is written to the shadow buffer at index/2, low byte on even index and high byte on odd index. The 16-bit sum is decremented by the byte value. After index 27 → CKLO.
- CKLO: latch the checksum low byte → CKHI.
- CKHI: latch the checksum high byte → CHECK.
- CHECK (taken without a strobe, one cycle), then → HDR0:
  - Checksum matches: copy the shadow buffer to the committed registers and pulse `frameValid`.
  - Checksum does not match: pulse `frameErr` and increment `errCount`; the committed registers are unchanged.

Gap abort:
- The gap counter clears on each strobe and otherwise increments, saturating.
- If the FSM is not in HDR0 and the counter reaches `GAP_CLKS`, the FSM returns to HDR0 silently: no error pulse and no count.
- A strobe in the same cycle as gap expiry wins: the byte is processed and the counter clears.

Read port:
- `chValue` is registered from `chSel` on every clock.
- `chSel` ≥ `CHANNELS` returns 0.

Reset values (`resetN` low, at any time including mid-frame):
- FSM returns to HDR0; the shadow buffer and committed channels clear to 0.
- `chValue`, `frameValid`, `frameErr`, `errCount` = 0.
- `failsafe` = 1 when `IBUS_FAILSAFE_EN` is defined, otherwise 0.

## Timing
- `frameValid` or `frameErr` rises on the second rising edge after the edge that samples the byte-31 strobe, and lasts exactly one cycle.
- The committed registers update on that same edge; `chValue` reflects the new data one edge later.
- The read port has one-cycle latency from `chSel`.
- The block accepts back-to-back strobes, at most one byte per cycle. The CHECK cycle never coincides with a strobe at legal UART rates. Any byte arriving during CHECK is dropped.
- `errCount` updates on the same edge as `frameErr`.

## Configuration
Macro: `IBUS_FAILSAFE_EN`.

Defined:
- A link counter clears on every commit and otherwise increments, saturating.
- `failsafe` sets when the counter reaches `TIMEOUT_CLKS`.
- `failsafe` clears on the commit edge.
- If commit and timeout occur on the same edge, commit wins and `failsafe` = 0.
- Committed channels hold their last values while `failsafe` = 1.

Not defined:
- No timer logic is synthesised and `failsafe` is tied to 0.

## Test plan
- Valid frame, ch[i]=1000+i, correct checksum → one `frameValid` pulse at the specified edge; `chSel`=5 reads 1005 after one cycle; `errCount`=0.
- Same frame with checksum byte 30 XOR 0x01 → `frameErr` pulse; `errCount`=1; `chSel`=5 still reads the prior value (0 after reset).
- Bytes 0x20, 0x20, 0x40, then a valid payload and checksum → frame commits (resync in HDR1).
- Valid frame with a `GAP_CLKS`+1 idle gap after byte 10, then a fresh valid frame → only the second frame commits; no `frameErr`.
- `IBUS_FAILSAFE_EN`: after reset `failsafe`=1; a valid frame clears it; no strobes for `TIMEOUT_CLKS` → `failsafe`=1 while channels hold their values. Assert `resetN` during byte 15, release, send a valid frame → clean commit.
- `chSel`=14 or 15 → `chValue`=0. Drive 300 bad-checksum frames → `errCount` saturates at 255.
